// File: rtl/mips_harness_pkg.sv
// Shared types and constants for the MIPS program-memory / run-control harness.
package mips_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPURST = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } harness_state_t;

  localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] MIPS_NOP          = 32'h0000_0000;

  // The CPU fetches little-endian words; programs are written MSB-first.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_prog_harness_mem.sv
// Program word store: synchronous write port, asynchronous read port.
module prog_word_mem #(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset; stale words are hidden by the write pointer, never read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mips_prog_harness.sv
// Loadable instruction memory plus reset/run/halt sequencing for mips_cpu_harvard benches.
module mips_prog_harness
  import mips_harness_pkg::*;
#(
  parameter int unsigned DEPTH        = 64,
  parameter logic [31:0] BASE_ADDR    = MIPS_RESET_VECTOR,
  parameter bit          BYTE_SWAP    = 1'b1,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        start,
  output logic        cpu_reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic        active,
  input  logic [31:0] register_v0,
  input  logic [31:0] expected_v0,
  output logic        done,
  output logic        pass,
  output logic        timed_out,
  output logic [31:0] cycle_count,
  output logic [31:0] final_v0
);

  localparam int unsigned AW           = $clog2(DEPTH);
  localparam int unsigned PW           = AW + 1;
  localparam int unsigned RW           = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [PW-1:0] PTR_FULL   = PW'(DEPTH);
  localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  harness_state_t state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0]    cycle_count_q, cycle_count_d;
  logic [31:0]    final_v0_q, final_v0_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           timed_out_q, timed_out_d;

  logic           wr_en;
  logic           launch;
  logic           halt;
  logic [29:0]    fetch_idx;
  logic           fetch_hit;
  logic [31:0]    mem_rdata;
  logic [31:0]    fetch_word;

  // A start in the same cycle as a load wins; the offered word is dropped.
  assign load_ready = (state_q == ST_IDLE) && (wr_ptr_q != PTR_FULL);
  assign wr_en      = load_ready && load_valid && !start;
  assign launch     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign halt       = (instr_address == 32'd0) && !active;

  // Addresses below BASE_ADDR wrap to huge indices and fall outside the loaded window.
  assign fetch_idx  = 30'((instr_address - BASE_ADDR) >> 2);
  assign fetch_hit  = 30'(wr_ptr_q) > fetch_idx;
  assign fetch_word = fetch_hit ? mem_rdata : MIPS_NOP;

  assign instr_readdata = BYTE_SWAP ? bswap32(fetch_word) : fetch_word;

  prog_word_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (load_data),
    .rd_addr (fetch_idx[AW-1:0]),
    .rd_data (mem_rdata)
  );

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no branch can infer a latch.
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    final_v0_d    = final_v0_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timed_out_d   = timed_out_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (launch) begin
      state_d       = ST_CPURST;
      rst_cnt_d     = '0;
      cycle_count_d = '0;
      done_d        = 1'b0;
      pass_d        = 1'b0;
      timed_out_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_CPURST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d = ST_RUN;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        ST_RUN: begin
          if (halt) begin
            final_v0_d = register_v0;
            pass_d     = (register_v0 == expected_v0);
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else if (cycle_count_q == TIMEOUT_LAST) begin
            timed_out_d = 1'b1;
            pass_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else if (cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + 32'd1;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      final_v0_q    <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      final_v0_q    <= final_v0_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timed_out_q   <= timed_out_d;
    end
  end

  // The CPU stays parked in reset whenever no run is in progress.
  assign cpu_reset   = (state_q != ST_RUN);
  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;
  assign final_v0    = final_v0_q;

endmodule

// File: doc/mips_prog_harness.md
# mips_prog_harness

Parametrised, reusable program-memory and run-control harness for `mips_cpu_harvard` benches. It replaces per-test hard-coded instruction decoders. A bench streams a program into a loadable word memory, pulses `start`, and the harness does the rest: it sequences CPU reset, serves instruction fetches in the CPU's byte order, detects the halt condition, and reports cycle count, final `register_v0` and pass/fail/timeout. It sits between the bench stimulus and the `mips_cpu_harvard` instruction port; the data memory is unaffected.

## Interface
- `DEPTH`, 64: program words held (power of two, ≥2).
- `BASE_ADDR`, 32'hBFC00000: byte address of word 0 (reset vector).
- `BYTE_SWAP`, 1: 1 = word byte-reversed on `instr_readdata`; 0 = stored order.
- `RESET_CYCLES`, 2: cycles `cpu_reset` is held after `start` (≥1).
- `TIMEOUT`, 1024: RUN-cycle limit before timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_valid` in 1: program word offered.
- `load_data` in 32: program word (instruction in natural MSB-first order).
- `load_ready` out 1: harness accepts word this cycle.
- `start` in 1: begin a run (single-cycle pulse, level tolerated).
- `cpu_reset` out 1: drives CPU `reset`.
- `instr_address` in 32: CPU fetch address.
- `instr_readdata` out 32: fetched word.
- `active` in 1, `register_v0` in 32: from CPU.
- `expected_v0` in 32: value to compare at halt.
- `done` out 1, `pass` out 1, `timed_out` out 1: run result, sticky.
- `cycle_count` out 32: RUN cycles elapsed.
- `final_v0` out 32: `register_v0` captured at halt.

## Operation
- States: IDLE, CPURST, RUN, DONE.
- IDLE: `load_ready` = (wr_ptr != DEPTH). A word is written on `load_valid && load_ready` at wr_ptr, and wr_ptr increments. Once wr_ptr = DEPTH, further words are dropped and `load_ready` = 0. `start` moves to CPURST and takes priority over a same-cycle load, which is dropped.
- CPURST: `cpu_reset` = 1 for RESET_CYCLES cycles, then RUN. `cycle_count` clears on entry.
- RUN: `cpu_reset` = 0. `cycle_count` increments each cycle, saturating at 2^32−1.
  - Halt: `instr_address == 0 && active == 0` sampled at a rising edge. On halt, `final_v0` ← `register_v0`, `pass` ← (`register_v0 == expected_v0`), `done` ← 1, go to DONE.
  - Timeout: if `cycle_count == TIMEOUT−1` and no halt, `timed_out` ← 1, `done` ← 1, `pass` ← 0, go to DONE. Halt and timeout in the same cycle: halt wins.
- DONE: outputs hold. `start` re-runs the same program: result flags clear, then CPURST. Loads are ignored (`load_ready` = 0).
- Loads are accepted only in IDLE; outside IDLE `load_ready` = 0.
- Fetch path (combinational, all states):
  - idx = (instr_address − BASE_ADDR) >> 2. Bits [1:0] are ignored.
  - If idx < wr_ptr: word = mem[idx], else word = 0 (NOP). This covers out-of-window, below-BASE (wraps large) and unwritten slots.
  - `instr_readdata` = BYTE_SWAP ? {w[7:0],w[15:8],w[23:16],w[31:24]} : w.
- Reset: state IDLE, wr_ptr 0, memory contents don't-care (masked by wr_ptr), `cpu_reset` 1, `done`/`pass`/`timed_out` 0, `cycle_count` 0, `final_v0` 0, `load_ready` 1. Reset mid-run aborts, discards the program and returns to IDLE.

## Timing
- Load: word written at the edge where `load_valid && load_ready`. It is fetchable from the next cycle.
- `start` at edge N: `cpu_reset` high from N+1 through N+RESET_CYCLES. First RUN cycle is N+RESET_CYCLES+1.
- `cpu_reset` is 1 in every state except RUN, so the CPU is parked until a run starts.
- Halt at edge H: `done`/`pass`/`final_v0` valid after H. `cycle_count` holds the number of RUN cycles before H.
- Fetch data has zero-cycle latency from `instr_address`.

## Structure
- Package `mips_harness_pkg`: state enum `harness_state_t`, `MIPS_RESET_VECTOR` = 32'hBFC00000, `MIPS_NOP` = 32'h0, byte-swap function `bswap32`.
- One sub-module, `prog_word_mem`: DEPTH×32 memory with synchronous write and async read. FSM, counters and compare stay in the top.

## Test plan
- SRAV program: load 24846006, 24210002, 00241007, 00000008, 24000000; `expected_v0` = 32'h00001801; start → `done` = 1, `pass` = 1, `final_v0` = 0x1801, `timed_out` = 0.
- Same run with `expected_v0` = 0x1800 → `done` = 1, `pass` = 0, `final_v0` = 0x1801.
- Program of a single `beq r0,r0,-1` (1000FFFF), TIMEOUT = 16 → `timed_out` = 1 at `cycle_count` = 15, `pass` = 0.
- Fill check: offer DEPTH+3 words → `load_ready` drops after word DEPTH; fetch at BASE+4·DEPTH and at 0x0 returns 0.
- BYTE_SWAP = 1: load 0x24846006 → fetch at BASE gives 0x06608424; BYTE_SWAP = 0 gives 0x24846006.
- Reset mid-RUN: `reset` in RUN cycle 3 → next cycle IDLE, `cpu_reset` = 1, `load_ready` = 1, all flags 0. A fetch at BASE returns 0. A re-run from DONE repeats the pass result with the same `cycle_count`.
